// File: rtl/reorder_buffer_pkg.sv
// rtl/reorder_buffer_pkg.sv - shared ROB types and sizes (package qu_common)
// Purpose: ROB depth, tag/count types and the per-entry record.
// Ports: none (package).
// Config macro used by the design: QU_ROB_CDB_BYPASS_EN (see reorder_buffer.sv).
package qu_common;

  localparam int ROB_DEPTH          = 16;
  localparam int ROB_ADDR_WIDTH     = $clog2(ROB_DEPTH);
  localparam int PHY_RF_ADDR_WIDTH  = 6;

  typedef logic [ROB_ADDR_WIDTH-1:0]    rob_addr_t;
  typedef logic [ROB_ADDR_WIDTH-1:0]    rob_cnt_t;   // 0..ROB_DEPTH-1 fits exactly
  typedef logic [PHY_RF_ADDR_WIDTH-1:0] phy_addr_t;

  typedef struct packed {
    logic      valid;
    logic      done;
    logic      dest_valid;
    phy_addr_t dest;
    phy_addr_t phyreg_old;
    logic [31:0] data;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// rtl/reorder_buffer_if.sv - allocate / CDB / retire signal bundle for the ROB
// Purpose: groups all ROB handshake signals.
// Modports: slave = ROB side (takes alloc/cdb, drives status/retire),
//           master = environment side (drives alloc/cdb, observes status/retire).
interface reorder_buffer_if import qu_common::*; ();

  logic        alloc_en;
  logic        alloc_dest_valid;
  phy_addr_t   alloc_dest;
  phy_addr_t   alloc_phyreg_old;
  rob_addr_t   rob_tail_ptr;
  logic        rob_full;
  logic        rob_empty;
  logic        cdb_valid;
  rob_addr_t   cdb_rob_addr;
  logic [31:0] cdb_data;
  logic        retire_en;
  rob_addr_t   retire_rob_addr;
  logic        retire_dest_valid;
  phy_addr_t   retire_dest;
  phy_addr_t   retire_phyreg_old;
  logic [31:0] retire_data;
  logic        alloc_overflow;

  modport slave (
    input  alloc_en, alloc_dest_valid, alloc_dest, alloc_phyreg_old,
    input  cdb_valid, cdb_rob_addr, cdb_data,
    output rob_tail_ptr, rob_full, rob_empty,
    output retire_en, retire_rob_addr, retire_dest_valid, retire_dest,
    output retire_phyreg_old, retire_data, alloc_overflow
  );

  modport master (
    output alloc_en, alloc_dest_valid, alloc_dest, alloc_phyreg_old,
    output cdb_valid, cdb_rob_addr, cdb_data,
    input  rob_tail_ptr, rob_full, rob_empty,
    input  retire_en, retire_rob_addr, retire_dest_valid, retire_dest,
    input  retire_phyreg_old, retire_data, alloc_overflow
  );

endinterface

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - in-order retirement buffer with 15 usable tags (tag 0 = no tag)
// Purpose: allocates entries at tail, marks them done from the CDB, retires the
//          head entry in order, one per cycle.
// Ports: clk (clock), rst (synchronous active-low reset),
//        rob (reorder_buffer_if.slave: alloc, cdb, status and retire signals).
// Config: define QU_ROB_CDB_BYPASS_EN to let a CDB hit on the head retire it in
//         the same cycle; undefined, completion is retire-visible one cycle later.
module reorder_buffer import qu_common::*; (
  input  logic             clk,
  input  logic             rst,
  reorder_buffer_if.slave  rob
);

  rob_entry_t entries [ROB_DEPTH];
  rob_addr_t  head;
  rob_addr_t  tail;
  rob_cnt_t   count;

  logic alloc_fire;
  logic cdb_hit;
  logic bypass_hit;

  // Tag 0 is reserved, so the wrap goes from ROB_DEPTH-1 straight to 1.
  function automatic rob_addr_t ptr_incr(rob_addr_t p);
    return (p == rob_addr_t'(ROB_DEPTH - 1)) ? rob_addr_t'(1) : p + rob_addr_t'(1);
  endfunction

  assign rob.rob_empty    = (count == rob_cnt_t'(0));
  assign rob.rob_full     = (count == rob_cnt_t'(ROB_DEPTH - 1));
  assign rob.rob_tail_ptr = tail;

  assign alloc_fire = rob.alloc_en && !rob.rob_full;
  assign cdb_hit    = rob.cdb_valid && (rob.cdb_rob_addr != rob_addr_t'(0)) &&
                      entries[rob.cdb_rob_addr].valid;

`ifdef QU_ROB_CDB_BYPASS_EN
  assign bypass_hit = cdb_hit && (rob.cdb_rob_addr == head) && !entries[head].done;
`else
  assign bypass_hit = 1'b0;
`endif

  always_comb begin
    rob.retire_en         = 1'b0;
    rob.retire_rob_addr   = '0;
    rob.retire_dest_valid = 1'b0;
    rob.retire_dest       = '0;
    rob.retire_phyreg_old = '0;
    rob.retire_data       = '0;
    if (!rob.rob_empty && (entries[head].done || bypass_hit)) begin
      rob.retire_en         = 1'b1;
      rob.retire_rob_addr   = head;
      rob.retire_dest_valid = entries[head].dest_valid;
      rob.retire_dest       = entries[head].dest;
      rob.retire_phyreg_old = entries[head].phyreg_old;
      rob.retire_data       = bypass_hit ? rob.cdb_data : entries[head].data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head               <= rob_addr_t'(1);
      tail               <= rob_addr_t'(1);
      count              <= '0;
      rob.alloc_overflow <= 1'b0;
      for (int i = 0; i < ROB_DEPTH; i++) entries[i] <= '0;
    end else begin
      if (cdb_hit) begin
        entries[rob.cdb_rob_addr].done <= 1'b1;
        entries[rob.cdb_rob_addr].data <= rob.cdb_data;
      end
      // Retire clear is placed after the CDB write so a bypassed head ends up empty.
      if (rob.retire_en) begin
        entries[head].valid <= 1'b0;
        entries[head].done  <= 1'b0;
        head                <= ptr_incr(head);
      end
      // tail never equals an occupied head unless full, and full blocks allocation.
      if (alloc_fire) begin
        entries[tail].valid      <= 1'b1;
        entries[tail].done       <= 1'b0;
        entries[tail].dest_valid <= rob.alloc_dest_valid;
        entries[tail].dest       <= rob.alloc_dest;
        entries[tail].phyreg_old <= rob.alloc_phyreg_old;
        entries[tail].data       <= '0;
        tail                     <= ptr_incr(tail);
      end
      unique case ({alloc_fire, rob.retire_en})
        2'b10:   count <= count + rob_cnt_t'(1);
        2'b01:   count <= count - rob_cnt_t'(1);
        default: count <= count;
      endcase
      if (rob.alloc_en && rob.rob_full) rob.alloc_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - directed self-checking bench for reorder_buffer
// Purpose: reset, fill/overflow, in-order retire, full+retire, bad CDB,
//          CDB bypass timing and mid-stream reset scenarios.
// Ports: none (top-level bench). Honours QU_ROB_CDB_BYPASS_EN for bypass timing.
module tb_reorder_buffer;
  import qu_common::*;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

  reorder_buffer_if rif ();

  reorder_buffer dut (
    .clk (clk),
    .rst (rst),
    .rob (rif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rif.alloc_en         = 1'b0;
    rif.alloc_dest_valid = 1'b0;
    rif.alloc_dest       = '0;
    rif.alloc_phyreg_old = '0;
    rif.cdb_valid        = 1'b0;
    rif.cdb_rob_addr     = '0;
    rif.cdb_data         = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  task automatic alloc_one(input logic dv, input phy_addr_t d, input phy_addr_t old);
    rif.alloc_en         = 1'b1;
    rif.alloc_dest_valid = dv;
    rif.alloc_dest       = d;
    rif.alloc_phyreg_old = old;
    step();
    rif.alloc_en = 1'b0;
  endtask

  task automatic cdb_one(input rob_addr_t tag, input logic [31:0] data);
    rif.cdb_valid    = 1'b1;
    rif.cdb_rob_addr = tag;
    rif.cdb_data     = data;
    step();
    rif.cdb_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++;
    if (rif.rob_tail_ptr !== 4'd1 || rif.rob_empty !== 1'b1 || rif.rob_full !== 1'b0 ||
        rif.alloc_overflow !== 1'b0)
      $display("FAIL reset_status: tail=%0d empty=%b full=%b ovf=%b want 1 1 0 0",
               rif.rob_tail_ptr, rif.rob_empty, rif.rob_full, rif.alloc_overflow);
    else pass_cnt++;
    total_cnt++;
    if (rif.retire_en !== 1'b0 || rif.retire_rob_addr !== 4'd0 || rif.retire_data !== 32'd0 ||
        rif.retire_dest !== 6'd0 || rif.retire_phyreg_old !== 6'd0 || rif.retire_dest_valid !== 1'b0)
      $display("FAIL reset_retire: en=%b addr=%0d data=%h want all zero",
               rif.retire_en, rif.retire_rob_addr, rif.retire_data);
    else pass_cnt++;
  endtask

  task automatic test_fill_overflow();
    do_reset();
    for (int i = 1; i <= 15; i++) begin
      total_cnt++;
      if (rif.rob_tail_ptr !== 4'(i) || rif.rob_full !== 1'b0)
        $display("FAIL fill_tail_%0d: tail=%0d full=%b want %0d 0", i, rif.rob_tail_ptr, rif.rob_full, i);
      else pass_cnt++;
      alloc_one(1'b1, 6'(i), 6'(i + 20));
    end
    total_cnt++;
    if (rif.rob_tail_ptr !== 4'd1 || rif.rob_full !== 1'b1 || rif.alloc_overflow !== 1'b0)
      $display("FAIL fill_full: tail=%0d full=%b ovf=%b want 1 1 0",
               rif.rob_tail_ptr, rif.rob_full, rif.alloc_overflow);
    else pass_cnt++;
    alloc_one(1'b1, 6'd63, 6'd63);
    total_cnt++;
    if (rif.rob_tail_ptr !== 4'd1 || rif.rob_full !== 1'b1 || rif.alloc_overflow !== 1'b1)
      $display("FAIL overflow: tail=%0d full=%b ovf=%b want 1 1 1",
               rif.rob_tail_ptr, rif.rob_full, rif.alloc_overflow);
    else pass_cnt++;
    step();
    total_cnt++;
    if (rif.alloc_overflow !== 1'b1 || rif.retire_en !== 1'b0)
      $display("FAIL overflow_sticky: ovf=%b ren=%b want 1 0", rif.alloc_overflow, rif.retire_en);
    else pass_cnt++;
  endtask

  task automatic test_in_order_retire();
    logic [31:0] exp_data [3];
    exp_data[0] = 32'hA; exp_data[1] = 32'hB; exp_data[2] = 32'hC;
    do_reset();
    alloc_one(1'b1, 6'd11, 6'd31);
    alloc_one(1'b0, 6'd12, 6'd32);
    alloc_one(1'b1, 6'd13, 6'd33);
    cdb_one(4'd3, 32'hC);
    total_cnt++;
    if (rif.retire_en !== 1'b0)
      $display("FAIL order_no_early_3: ren=%b want 0", rif.retire_en);
    else pass_cnt++;
    cdb_one(4'd2, 32'hB);
    total_cnt++;
    if (rif.retire_en !== 1'b0)
      $display("FAIL order_no_early_2: ren=%b want 0", rif.retire_en);
    else pass_cnt++;
    cdb_one(4'd1, 32'hA);
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if (rif.retire_en !== 1'b1 || rif.retire_rob_addr !== 4'(i + 1) ||
          rif.retire_data !== exp_data[i] || rif.retire_dest !== 6'(11 + i) ||
          rif.retire_phyreg_old !== 6'(31 + i) || rif.retire_dest_valid !== (i != 1))
        $display("FAIL order_retire_%0d: en=%b addr=%0d data=%h dest=%0d old=%0d dv=%b want 1 %0d %h %0d %0d %b",
                 i, rif.retire_en, rif.retire_rob_addr, rif.retire_data, rif.retire_dest,
                 rif.retire_phyreg_old, rif.retire_dest_valid, i + 1, exp_data[i], 11 + i, 31 + i, i != 1);
      else pass_cnt++;
      step();
    end
    total_cnt++;
    if (rif.retire_en !== 1'b0 || rif.rob_empty !== 1'b1 || rif.retire_data !== 32'd0)
      $display("FAIL order_drained: ren=%b empty=%b data=%h want 0 1 0",
               rif.retire_en, rif.rob_empty, rif.retire_data);
    else pass_cnt++;
  endtask

  task automatic test_full_retire_alloc();
    do_reset();
    for (int i = 1; i <= 15; i++) alloc_one(1'b1, 6'(i), 6'(i));
    cdb_one(4'd1, 32'h1234);
    rif.alloc_en = 1'b1;
    rif.alloc_dest = 6'd50;
    total_cnt++;
    if (rif.retire_en !== 1'b1 || rif.rob_full !== 1'b1 || rif.retire_data !== 32'h1234)
      $display("FAIL full_retire_pre: ren=%b full=%b data=%h want 1 1 1234",
               rif.retire_en, rif.rob_full, rif.retire_data);
    else pass_cnt++;
    step();
    rif.alloc_en = 1'b0;
    total_cnt++;
    if (rif.rob_full !== 1'b0 || rif.rob_tail_ptr !== 4'd1 || rif.alloc_overflow !== 1'b1)
      $display("FAIL full_retire_reject: full=%b tail=%0d ovf=%b want 0 1 1",
               rif.rob_full, rif.rob_tail_ptr, rif.alloc_overflow);
    else pass_cnt++;
    alloc_one(1'b1, 6'd51, 6'd52);
    total_cnt++;
    if (rif.rob_full !== 1'b1 || rif.rob_tail_ptr !== 4'd2)
      $display("FAIL full_retire_realloc: full=%b tail=%0d want 1 2", rif.rob_full, rif.rob_tail_ptr);
    else pass_cnt++;
  endtask

  task automatic test_bad_cdb();
    do_reset();
    alloc_one(1'b1, 6'd1, 6'd2);
    alloc_one(1'b1, 6'd3, 6'd4);
    cdb_one(4'd5, 32'hDEAD);
    total_cnt++;
    if (rif.retire_en !== 1'b0 || rif.rob_tail_ptr !== 4'd3 || rif.rob_empty !== 1'b0)
      $display("FAIL bad_cdb_5: ren=%b tail=%0d empty=%b want 0 3 0",
               rif.retire_en, rif.rob_tail_ptr, rif.rob_empty);
    else pass_cnt++;
    cdb_one(4'd0, 32'hBEEF);
    total_cnt++;
    if (rif.retire_en !== 1'b0 || rif.rob_tail_ptr !== 4'd3 || rif.rob_empty !== 1'b0)
      $display("FAIL bad_cdb_0: ren=%b tail=%0d empty=%b want 0 3 0",
               rif.retire_en, rif.rob_tail_ptr, rif.rob_empty);
    else pass_cnt++;
    alloc_one(1'b1, 6'd5, 6'd6);
    alloc_one(1'b1, 6'd7, 6'd8);
    alloc_one(1'b1, 6'd9, 6'd10);
    for (int i = 1; i <= 4; i++) cdb_one(4'(i), 32'(i));
    for (int i = 0; i < 4; i++) step();
    total_cnt++;
    if (rif.retire_en !== 1'b0 || rif.rob_empty !== 1'b0 || rif.rob_tail_ptr !== 4'd6)
      $display("FAIL bad_cdb_tag5_pending: ren=%b empty=%b tail=%0d want 0 0 6",
               rif.retire_en, rif.rob_empty, rif.rob_tail_ptr);
    else pass_cnt++;
  endtask

  task automatic test_bypass();
    do_reset();
    alloc_one(1'b1, 6'd9, 6'd19);
    rif.cdb_valid    = 1'b1;
    rif.cdb_rob_addr = 4'd1;
    rif.cdb_data     = 32'h55;
    #1;
`ifdef QU_ROB_CDB_BYPASS_EN
    total_cnt++;
    if (rif.retire_en !== 1'b1 || rif.retire_data !== 32'h55 || rif.retire_rob_addr !== 4'd1)
      $display("FAIL bypass_same_cycle: ren=%b data=%h addr=%0d want 1 55 1",
               rif.retire_en, rif.retire_data, rif.retire_rob_addr);
    else pass_cnt++;
    step();
    rif.cdb_valid = 1'b0;
    total_cnt++;
    if (rif.retire_en !== 1'b0 || rif.rob_empty !== 1'b1)
      $display("FAIL bypass_after: ren=%b empty=%b want 0 1", rif.retire_en, rif.rob_empty);
    else pass_cnt++;
`else
    total_cnt++;
    if (rif.retire_en !== 1'b0)
      $display("FAIL nobypass_same_cycle: ren=%b want 0", rif.retire_en);
    else pass_cnt++;
    step();
    rif.cdb_valid = 1'b0;
    total_cnt++;
    if (rif.retire_en !== 1'b1 || rif.retire_data !== 32'h55 || rif.retire_rob_addr !== 4'd1)
      $display("FAIL nobypass_next_cycle: ren=%b data=%h addr=%0d want 1 55 1",
               rif.retire_en, rif.retire_data, rif.retire_rob_addr);
    else pass_cnt++;
    step();
    total_cnt++;
    if (rif.retire_en !== 1'b0 || rif.rob_empty !== 1'b1)
      $display("FAIL nobypass_after: ren=%b empty=%b want 0 1", rif.retire_en, rif.rob_empty);
    else pass_cnt++;
`endif
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 1; i <= 7; i++) alloc_one(1'b1, 6'(i), 6'(i));
    cdb_one(4'd1, 32'h77);
    total_cnt++;
    if (rif.rob_tail_ptr !== 4'd8 || rif.retire_en !== 1'b1)
      $display("FAIL midrst_pre: tail=%0d ren=%b want 8 1", rif.rob_tail_ptr, rif.retire_en);
    else pass_cnt++;
    rst              = 1'b0;
    rif.alloc_en     = 1'b1;
    rif.cdb_valid    = 1'b1;
    rif.cdb_rob_addr = 4'd2;
    rif.cdb_data     = 32'h88;
    step();
    rst = 1'b1;
    idle_inputs();
    total_cnt++;
    if (rif.rob_empty !== 1'b1 || rif.rob_tail_ptr !== 4'd1 || rif.retire_en !== 1'b0 ||
        rif.rob_full !== 1'b0 || rif.retire_data !== 32'd0)
      $display("FAIL midrst_post: empty=%b tail=%0d ren=%b full=%b data=%h want 1 1 0 0 0",
               rif.rob_empty, rif.rob_tail_ptr, rif.retire_en, rif.rob_full, rif.retire_data);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst = 1'b0;
    idle_inputs();
    test_reset();
    test_fill_overflow();
    test_in_order_retire();
    test_full_retire_alloc();
    test_bad_cdb();
    test_bypass();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
